// File: rtl/color_locate_if.sv
`default_nettype none
// ============================================================================
// Module   : color_locate_if
// Purpose  : Pixel-in / mask-and-results-out bundle for color_locate.
//            master = pixel source / result consumer, slave = color_locate.
// Revision : 1.0  initial release
// ============================================================================
interface color_locate_if #(
  parameter int IMG_W = 480,
  parameter int IMG_H = 480
);
  localparam int CW = $clog2(IMG_W * IMG_H + 1);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  // pixel stream and thresholds
  logic          i_sof;
  logic          i_valid;
  logic [15:0]   i_data;
  logic [4:0]    i_rmin;
  logic [4:0]    i_rmax;
  logic [5:0]    i_gmin;
  logic [5:0]    i_gmax;
  logic [4:0]    i_bmin;
  logic [4:0]    i_bmax;

  // mask stream and frame results
  logic          o_mask_valid;
  logic          o_mask;
  logic          o_done;
  logic          o_found;
  logic [CW-1:0] o_count;
  logic [XW-1:0] o_xmin;
  logic [XW-1:0] o_xmax;
  logic [YW-1:0] o_ymin;
  logic [YW-1:0] o_ymax;

  modport master (
    output i_sof, i_valid, i_data, i_rmin, i_rmax, i_gmin, i_gmax, i_bmin, i_bmax,
    input  o_mask_valid, o_mask, o_done, o_found, o_count,
           o_xmin, o_xmax, o_ymin, o_ymax
  );

  modport slave (
    input  i_sof, i_valid, i_data, i_rmin, i_rmax, i_gmin, i_gmax, i_bmin, i_bmax,
    output o_mask_valid, o_mask, o_done, o_found, o_count,
           o_xmin, o_xmax, o_ymin, o_ymax
  );
endinterface
`default_nettype wire

// File: rtl/color_locate.sv
`default_nettype none
// ============================================================================
// Module   : color_locate
// Purpose  : Classifies RGB565 pixels against a per-channel window, emits a
//            1-bit mask stream, and reports per-frame match count and
//            bounding box with a one-cycle done strobe at end of frame.
// Revision : 1.0  initial release
// ============================================================================
module color_locate #(
  parameter int IMG_W = 480,
  parameter int IMG_H = 480
) (
  input  logic          i_pclk,
  input  logic          i_rstn,
  color_locate_if.slave bus
);
  localparam int CW = $clog2(IMG_W * IMG_H + 1);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [XW-1:0] C_X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] C_Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;

  // shadow thresholds, frozen at start of frame
  logic [4:0]    r_rmin, r_rmax, r_bmin, r_bmax;
  logic [5:0]    r_gmin, r_gmax;

  // pixel position of the next accepted pixel
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  // stage 1: classified pixel
  logic          r_s1_valid;
  logic          r_s1_match;
  logic          r_s1_last;
  logic [XW-1:0] r_s1_x;
  logic [YW-1:0] r_s1_y;

  // running per-frame accumulators
  logic          r_any;
  logic [CW-1:0] r_cnt;
  logic [XW-1:0] r_xmin, r_xmax;
  logic [YW-1:0] r_ymin, r_ymax;

  // latched results of the last complete frame
  logic          r_done;
  logic          r_found;
  logic [CW-1:0] r_count;
  logic [XW-1:0] r_oxmin, r_oxmax;
  logic [YW-1:0] r_oymin, r_oymax;

  // stage 0 combinational signals
  logic          w_accept;
  logic          w_match;
  logic          w_last;
  logic [XW-1:0] w_px;
  logic [YW-1:0] w_py;
  logic [4:0]    w_rmin, w_rmax, w_bmin, w_bmax;
  logic [5:0]    w_gmin, w_gmax;
  logic [4:0]    w_r, w_b;
  logic [5:0]    w_g;

  // stage 2 combinational signals: accumulators including the stage-1 pixel
  logic          w_any_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [XW-1:0] w_xmin_nx, w_xmax_nx;
  logic [YW-1:0] w_ymin_nx, w_ymax_nx;

  // Pixel acceptance, position and window classification; sof takes effect
  // first so a same-cycle pixel is (0,0) judged against the new thresholds.
  always_comb begin
    w_accept = bus.i_valid && (bus.i_sof || (r_state == ST_ACTIVE));
    w_px     = bus.i_sof ? '0 : r_x;
    w_py     = bus.i_sof ? '0 : r_y;
    w_last   = (w_px == C_X_LAST) && (w_py == C_Y_LAST);
    w_rmin   = bus.i_sof ? bus.i_rmin : r_rmin;
    w_rmax   = bus.i_sof ? bus.i_rmax : r_rmax;
    w_gmin   = bus.i_sof ? bus.i_gmin : r_gmin;
    w_gmax   = bus.i_sof ? bus.i_gmax : r_gmax;
    w_bmin   = bus.i_sof ? bus.i_bmin : r_bmin;
    w_bmax   = bus.i_sof ? bus.i_bmax : r_bmax;
    w_r      = bus.i_data[15:11];
    w_g      = bus.i_data[10:5];
    w_b      = bus.i_data[4:0];
    // an inverted window (min > max) can never satisfy both bounds
    w_match  = (w_r >= w_rmin) && (w_r <= w_rmax) &&
               (w_g >= w_gmin) && (w_g <= w_gmax) &&
               (w_b >= w_bmin) && (w_b <= w_bmax);
  end

  // Frame state: sof always restarts; the final pixel parks us in FULL.
  always_comb begin
    w_state_nx = r_state;
    if (w_accept && w_last) begin
      w_state_nx = ST_FULL;
    end else if (bus.i_sof) begin
      w_state_nx = ST_ACTIVE;
    end
  end

  // State register.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Shadow thresholds, pixel position counters and the stage-1 register.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rmin     <= '0;
      r_rmax     <= '0;
      r_gmin     <= '0;
      r_gmax     <= '0;
      r_bmin     <= '0;
      r_bmax     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_s1_valid <= 1'b0;
      r_s1_match <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
    end else begin
      if (bus.i_sof) begin
        r_rmin <= bus.i_rmin;
        r_rmax <= bus.i_rmax;
        r_gmin <= bus.i_gmin;
        r_gmax <= bus.i_gmax;
        r_bmin <= bus.i_bmin;
        r_bmax <= bus.i_bmax;
      end
      if (w_accept) begin
        if (w_last) begin
          r_x <= '0;
          r_y <= '0;
        end else if (w_px == C_X_LAST) begin
          r_x <= '0;
          r_y <= w_py + YW'(1);
        end else begin
          r_x <= w_px + XW'(1);
          r_y <= w_py;
        end
      end else if (bus.i_sof) begin
        r_x <= '0;
        r_y <= '0;
      end
      r_s1_valid <= w_accept;
      r_s1_match <= w_accept && w_match;
      r_s1_last  <= w_accept && w_last;
      r_s1_x     <= w_px;
      r_s1_y     <= w_py;
    end
  end

  // Fold the stage-1 pixel into the running count and bounding box.
  always_comb begin
    w_any_nx  = r_any | r_s1_match;
    w_cnt_nx  = r_cnt + CW'(r_s1_match);
    w_xmin_nx = r_xmin;
    w_xmax_nx = r_xmax;
    w_ymin_nx = r_ymin;
    w_ymax_nx = r_ymax;
    if (r_s1_match) begin
      if (!r_any) begin
        w_xmin_nx = r_s1_x;
        w_xmax_nx = r_s1_x;
        w_ymin_nx = r_s1_y;
        w_ymax_nx = r_s1_y;
      end else begin
        if (r_s1_x < r_xmin) w_xmin_nx = r_s1_x;
        if (r_s1_x > r_xmax) w_xmax_nx = r_s1_x;
        if (r_s1_y < r_ymin) w_ymin_nx = r_s1_y;
        if (r_s1_y > r_ymax) w_ymax_nx = r_s1_y;
      end
    end
  end

  // Stage 2: accumulate, and publish results when the last pixel arrives.
  // A stage-1 pixel always belongs to the frame before any sof seen on this
  // edge, so the last pixel still completes its frame and sof then clears.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_any   <= 1'b0;
      r_cnt   <= '0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymin  <= '0;
      r_ymax  <= '0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_count <= '0;
      r_oxmin <= '0;
      r_oxmax <= '0;
      r_oymin <= '0;
      r_oymax <= '0;
    end else begin
      r_done <= r_s1_last;
      if (r_s1_last) begin
        r_found <= w_any_nx;
        r_count <= w_cnt_nx;
        r_oxmin <= w_xmin_nx;
        r_oxmax <= w_xmax_nx;
        r_oymin <= w_ymin_nx;
        r_oymax <= w_ymax_nx;
      end
      if (bus.i_sof || r_s1_last) begin
        r_any  <= 1'b0;
        r_cnt  <= '0;
        r_xmin <= '0;
        r_xmax <= '0;
        r_ymin <= '0;
        r_ymax <= '0;
      end else begin
        r_any  <= w_any_nx;
        r_cnt  <= w_cnt_nx;
        r_xmin <= w_xmin_nx;
        r_xmax <= w_xmax_nx;
        r_ymin <= w_ymin_nx;
        r_ymax <= w_ymax_nx;
      end
    end
  end

  assign bus.o_mask_valid = r_s1_valid;
  assign bus.o_mask       = r_s1_match;
  assign bus.o_done       = r_done;
  assign bus.o_found      = r_found;
  assign bus.o_count      = r_count;
  assign bus.o_xmin       = r_oxmin;
  assign bus.o_xmax       = r_oxmax;
  assign bus.o_ymin       = r_oymin;
  assign bus.o_ymax       = r_oymax;

endmodule
`default_nettype wire

// File: tb/tb_color_locate.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_locate
// Purpose  : Randomised scoreboard bench for color_locate on a reduced image.
// Revision : 1.0  initial release
// ============================================================================
module tb_color_locate;
  localparam int W = 20;
  localparam int H = 12;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  color_locate_if #(.IMG_W(W), .IMG_H(H)) bus ();

  color_locate #(.IMG_W(W), .IMG_H(H)) u_dut (
    .i_pclk (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  typedef struct {
    int stamp;
    int m;
  } mask_t;

  typedef struct {
    int stamp;
    int found;
    int count;
    int xmin;
    int xmax;
    int ymin;
    int ymax;
  } res_t;

  mask_t mq[$];
  res_t  rq[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;

  // thresholds the bench is currently presenting
  int t_rmin, t_rmax, t_gmin, t_gmax, t_bmin, t_bmax;
  // reference model: thresholds captured at sof, frame progress, match list
  int s_rmin, s_rmax, s_gmin, s_gmax, s_bmin, s_bmax;
  bit m_active = 1'b0;
  int m_idx = 0;
  int hx[$];
  int hy[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference behaviour applied to one input cycle presented before edge c+1
  task automatic model(input bit sof, input bit valid, input logic [15:0] d, input int c);
    int x, y, r, g, b, mt;
    res_t e;
    if (sof) begin
      m_active = 1'b1;
      m_idx = 0;
      hx.delete();
      hy.delete();
      s_rmin = t_rmin; s_rmax = t_rmax;
      s_gmin = t_gmin; s_gmax = t_gmax;
      s_bmin = t_bmin; s_bmax = t_bmax;
    end
    if (valid && m_active) begin
      x = m_idx % W;
      y = m_idx / W;
      r = int'(d[15:11]);
      g = int'(d[10:5]);
      b = int'(d[4:0]);
      mt = (r >= s_rmin && r <= s_rmax && g >= s_gmin && g <= s_gmax &&
            b >= s_bmin && b <= s_bmax) ? 1 : 0;
      mq.push_back('{stamp: c + 1, m: mt});
      if (mt != 0) begin
        hx.push_back(x);
        hy.push_back(y);
      end
      m_idx++;
      if (m_idx == N) begin
        m_active = 1'b0;
        e.stamp = c + 2;
        e.count = hx.size();
        e.found = (hx.size() != 0) ? 1 : 0;
        e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0;
        if (hx.size() != 0) begin
          e.xmin = W; e.xmax = -1; e.ymin = H; e.ymax = -1;
          foreach (hx[i]) begin
            if (hx[i] < e.xmin) e.xmin = hx[i];
            if (hx[i] > e.xmax) e.xmax = hx[i];
            if (hy[i] < e.ymin) e.ymin = hy[i];
            if (hy[i] > e.ymax) e.ymax = hy[i];
          end
        end
        rq.push_back(e);
      end
    end
  endtask

  task automatic drive(input bit sof, input bit valid, input logic [15:0] d);
    @(negedge clk);
    bus.i_sof   = sof;
    bus.i_valid = valid;
    bus.i_data  = d;
    bus.i_rmin  = 5'(t_rmin); bus.i_rmax = 5'(t_rmax);
    bus.i_gmin  = 6'(t_gmin); bus.i_gmax = 6'(t_gmax);
    bus.i_bmin  = 5'(t_bmin); bus.i_bmax = 5'(t_bmax);
    model(sof, valid, d, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'(i));
  endtask

  task automatic set_win(input int rl, input int rh, input int gl, input int gh,
                         input int bl, input int bh);
    t_rmin = rl; t_rmax = rh; t_gmin = gl; t_gmax = gh; t_bmin = bl; t_bmax = bh;
  endtask

  task automatic rand_win();
    t_rmin = $urandom_range(31); t_rmax = $urandom_range(31, t_rmin);
    t_gmin = $urandom_range(63); t_gmax = $urandom_range(63, t_gmin);
    t_bmin = $urandom_range(31); t_bmax = $urandom_range(31, t_bmin);
  endtask

  function automatic logic [15:0] pix(input int mode, input int k);
    logic [15:0] v;
    case (mode)
      0:       v = 16'h0000;
      1:       v = (k == 5 * W + 7) ? 16'hF800 : 16'h07E0;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  // one frame of npix pixels; thresholds re-randomised after chg_at pixels
  task automatic frame(input int npix, input int mode, input int gap_pct,
                       input bit sof_with_pix, input int chg_at);
    int k = 0;
    if (sof_with_pix) begin
      drive(1'b1, 1'b1, pix(mode, 0));
      k = 1;
    end else begin
      drive(1'b1, 1'b0, 16'h0);
    end
    while (k < npix) begin
      if (k == chg_at) rand_win();
      if (int'($urandom_range(99)) < gap_pct) begin
        drive(1'b0, 1'b0, 16'($urandom));
      end else begin
        drive(1'b0, 1'b1, pix(mode, k));
        k++;
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_found"}, int'(bus.o_found), 0);
    check({tag, "_count"}, int'(bus.o_count), 0);
    check({tag, "_box"}, int'(bus.o_xmin) + int'(bus.o_xmax) +
                         int'(bus.o_ymin) + int'(bus.o_ymax), 0);
    check({tag, "_mask_valid"}, int'(bus.o_mask_valid), 0);
    check({tag, "_done"}, int'(bus.o_done), 0);
  endtask

  // Monitor: pops expected mask/result entries as the DUT presents them.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.o_mask_valid) begin
        if (mq.size() == 0) begin
          check("mask_spurious", int'(bus.o_mask_valid), 0);
        end else begin
          mask_t e;
          e = mq.pop_front();
          check("mask_time", cyc, e.stamp);
          check("mask_val", int'(bus.o_mask), e.m);
        end
      end else if (mq.size() != 0 && mq[0].stamp <= cyc) begin
        check("mask_missing", int'(bus.o_mask_valid), 1);
        void'(mq.pop_front());
      end
      if (bus.o_done) begin
        if (rq.size() == 0) begin
          check("done_spurious", int'(bus.o_done), 0);
        end else begin
          res_t e;
          e = rq.pop_front();
          check("done_time", cyc, e.stamp);
          check("res_found", int'(bus.o_found), e.found);
          check("res_count", int'(bus.o_count), e.count);
          check("res_xmin", int'(bus.o_xmin), e.xmin);
          check("res_xmax", int'(bus.o_xmax), e.xmax);
          check("res_ymin", int'(bus.o_ymin), e.ymin);
          check("res_ymax", int'(bus.o_ymax), e.ymax);
        end
      end else if (rq.size() != 0 && rq[0].stamp <= cyc) begin
        check("done_missing", int'(bus.o_done), 1);
        void'(rq.pop_front());
      end
    end
  end

  initial begin
    bus.i_sof = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0;
    set_win(0, 0, 0, 0, 0, 0);
    bus.i_rmin = '0; bus.i_rmax = '0; bus.i_gmin = '0;
    bus.i_gmax = '0; bus.i_bmin = '0; bus.i_bmax = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;

    // pixels without a preceding sof are ignored
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 16'($urandom));
    idle(3);
    check_outputs_zero("idle");

    // full window on an all-black frame
    set_win(0, 31, 0, 63, 0, 31);
    frame(N, 0, 0, 1'b0, -1);
    idle(4);
    check("full_count", int'(bus.o_count), N);
    check("full_xmax", int'(bus.o_xmax), W - 1);
    check("full_ymax", int'(bus.o_ymax), H - 1);

    // single red pixel
    set_win(28, 31, 0, 7, 0, 3);
    frame(N, 1, 10, 1'b0, -1);
    idle(4);
    check("red_count", int'(bus.o_count), 1);
    check("red_xmin", int'(bus.o_xmin), 7);
    check("red_ymin", int'(bus.o_ymin), 5);

    // inverted red window never matches
    set_win(5, 4, 0, 63, 0, 31);
    frame(N, 2, 20, 1'b1, -1);
    idle(4);
    check("none_found", int'(bus.o_found), 0);

    // short frame, then a full frame, then ignored trailing pixels
    rand_win();
    frame(100, 2, 0, 1'b0, -1);
    t_rmin = 0; t_rmax = 31; t_gmin = 10; t_gmax = 50; t_bmin = 3; t_bmax = 28;
    frame(N, 2, 15, 1'b1, -1);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 16'($urandom));
    idle(3);

    // back-to-back frames (sof lands while the last pixel is in stage 2),
    // with thresholds changing mid-frame
    for (int f = 0; f < 4; f++) begin
      rand_win();
      frame(N, 2, (f % 2) * 25, f[0], N / 2);
    end
    idle(4);

    // async reset mid-frame after a completed frame
    set_win(0, 31, 0, 63, 0, 31);
    frame(N, 2, 0, 1'b0, -1);
    frame(150, 2, 0, 1'b1, -1);
    idle(3);
    @(negedge clk);
    #2 rstn = 1'b0;
    m_active = 1'b0;
    #1 check_outputs_zero("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 16'($urandom));
    idle(2);
    check_outputs_zero("post_rst");
    rand_win();
    frame(N, 2, 10, 1'b1, -1);
    idle(6);

    check("mask_queue_drained", mq.size(), 0);
    check("result_queue_drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
